// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-lite register slave.
package axi_lite_pkg;

    localparam int ADDR_LSB = 3;
    localparam int DATA_W   = 64;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    // An address hits when the upper bits are clear and the word index is in range.
    function automatic logic addr_hit(input logic [63:0] addr, input int unsigned num_regs);
        return (addr[63:11] == '0) && (32'(addr[10:ADDR_LSB]) < num_regs);
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Bank of 64-bit registers with a byte-enable write port and an
// asynchronous read port selected by word index.
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int                NUM_REGS  = 16,
    parameter int                IDX_W     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [7:0]        wr_strb,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Each register loads RESET_VAL on reset and merges strobed bytes on write.
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem[gi] <= RESET_VAL;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < 8; b++) begin
                        if (wr_strb[b]) begin
                            mem[gi][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register slave: independent write and read FSMs in front of a
// register bank, echoing transaction IDs.
// Optional macro AXIL_ERR_RESP_EN: when defined, address misses answer SLVERR
// instead of OKAY.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter int          ID_W      = 4,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [63:0]     aw_addr,
    input  logic            aw_valid,
    input  logic [ID_W-1:0] aw_id,
    input  logic [2:0]      aw_prot,
    output logic            aw_ready,
    input  logic [63:0]     wdata,
    input  logic            wvalid,
    input  logic [7:0]      wstrb,
    output logic            wready,
    output logic            bvalid,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    input  logic            bready,
    input  logic [63:0]     ar_addr,
    input  logic            ar_valid,
    input  logic [ID_W-1:0] ar_id,
    input  logic [2:0]      ar_prot,
    output logic            ar_ready,
    output logic [63:0]     rdata,
    output logic            rvalid,
    output logic [ID_W-1:0] rid,
    output logic [1:0]      rresp,
    input  logic            rready
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_ERR_RESP_EN
    localparam axil_resp_t MISS_RESP = SLVERR;
`else
    localparam axil_resp_t MISS_RESP = OKAY;
`endif

    wr_state_t         wr_state_reg, wr_state_next;
    rd_state_t         rd_state_reg, rd_state_next;
    logic [63:0]       aw_addr_reg;
    logic [ID_W-1:0]   aw_id_reg;
    logic [63:0]       wdata_reg;
    logic [7:0]        wstrb_reg;
    logic              aw_ready_reg, wready_reg, ar_ready_reg;
    logic              bvalid_reg, rvalid_reg;
    logic [ID_W-1:0]   bid_reg, rid_reg;
    axil_resp_t        bresp_reg, rresp_reg;
    logic [63:0]       rdata_reg;

    logic              aw_hs, w_hs, ar_hs;
    logic [63:0]       eff_addr;
    logic [ID_W-1:0]   eff_id;
    logic [63:0]       eff_wdata;
    logic [7:0]        eff_wstrb;
    logic              wr_commit, wr_hit, rd_hit;
    logic [63:0]       bank_rd_data;
    logic              unused_ok;

    // Readies are registered so no input reaches an output combinationally.
    assign aw_hs = aw_valid && aw_ready_reg;
    assign w_hs  = wvalid && wready_reg;
    assign ar_hs = ar_valid && ar_ready_reg;

    // A channel that already handshook supplies its latched copy; otherwise the live bus.
    assign eff_addr  = (wr_state_reg == W_HAVE_AW) ? aw_addr_reg : aw_addr;
    assign eff_id    = (wr_state_reg == W_HAVE_AW) ? aw_id_reg   : aw_id;
    assign eff_wdata = (wr_state_reg == W_HAVE_W)  ? wdata_reg   : wdata;
    assign eff_wstrb = (wr_state_reg == W_HAVE_W)  ? wstrb_reg   : wstrb;

    assign wr_commit = (wr_state_reg != W_RESP) && (wr_state_next == W_RESP);
    assign wr_hit    = addr_hit(eff_addr, 32'(NUM_REGS));
    assign rd_hit    = addr_hit(ar_addr, 32'(NUM_REGS));

    assign unused_ok = ^{aw_prot, ar_prot};

    axi_lite_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk     (aclk),
        .srst    (arst),
        .wr_en   (wr_commit && wr_hit),
        .wr_idx  (eff_addr[ADDR_LSB +: IDX_W]),
        .wr_data (eff_wdata),
        .wr_strb (eff_wstrb),
        .rd_idx  (ar_addr[ADDR_LSB +: IDX_W]),
        .rd_data (bank_rd_data)
    );

    // Write FSM next state: collect AW and W in either order, then hold the response.
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs)  wr_state_next = W_RESP;
                else if (aw_hs)     wr_state_next = W_HAVE_AW;
                else if (w_hs)      wr_state_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)   wr_state_next = W_RESP;
            W_HAVE_W:  if (aw_hs)  wr_state_next = W_RESP;
            W_RESP:    if (bready) wr_state_next = W_IDLE;
            default:               wr_state_next = W_IDLE;
        endcase
    end

    // Write state, channel captures, registered readies and the B response.
    always_ff @(posedge aclk) begin
        if (arst) begin
            wr_state_reg <= W_IDLE;
            aw_addr_reg  <= '0;
            aw_id_reg    <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            aw_ready_reg <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bid_reg      <= '0;
            bresp_reg    <= OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            aw_ready_reg <= (wr_state_next == W_IDLE) || (wr_state_next == W_HAVE_W);
            wready_reg   <= (wr_state_next == W_IDLE) || (wr_state_next == W_HAVE_AW);
            bvalid_reg   <= (wr_state_next == W_RESP);
            if (aw_hs) begin
                aw_addr_reg <= aw_addr;
                aw_id_reg   <= aw_id;
            end
            if (w_hs) begin
                wdata_reg <= wdata;
                wstrb_reg <= wstrb;
            end
            if (wr_commit) begin
                bid_reg   <= eff_id;
                bresp_reg <= wr_hit ? OKAY : MISS_RESP;
            end
        end
    end

    // Read FSM next state: one outstanding read, released by rready.
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (ar_hs)  rd_state_next = R_RESP;
            R_RESP:  if (rready) rd_state_next = R_IDLE;
            default:             rd_state_next = R_IDLE;
        endcase
    end

    // Read state and the registered R response; the bank is sampled at the AR edge.
    always_ff @(posedge aclk) begin
        if (arst) begin
            rd_state_reg <= R_IDLE;
            ar_ready_reg <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rid_reg      <= '0;
            rresp_reg    <= OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            ar_ready_reg <= (rd_state_next == R_IDLE);
            rvalid_reg   <= (rd_state_next == R_RESP);
            if (ar_hs) begin
                rdata_reg <= rd_hit ? bank_rd_data : '0;
                rid_reg   <= ar_id;
                rresp_reg <= rd_hit ? OKAY : MISS_RESP;
            end
        end
    end

    assign aw_ready = aw_ready_reg;
    assign wready   = wready_reg;
    assign bvalid   = bvalid_reg;
    assign bid      = bid_reg;
    assign bresp    = bresp_reg;
    assign ar_ready = ar_ready_reg;
    assign rvalid   = rvalid_reg;
    assign rdata    = rdata_reg;
    assign rid      = rid_reg;
    assign rresp    = rresp_reg;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed testbench for axi_lite_reg_slave (default NUM_REGS=16, RESET_VAL=0).
module tb_axi_lite_reg_slave;

`ifdef AXIL_ERR_RESP_EN
    localparam logic [1:0] MISS_EXP = 2'b10;
`else
    localparam logic [1:0] MISS_EXP = 2'b00;
`endif

    logic        aclk = 1'b0;
    logic        arst;
    logic [63:0] aw_addr;
    logic        aw_valid;
    logic [3:0]  aw_id;
    logic [2:0]  aw_prot;
    logic        aw_ready;
    logic [63:0] wdata;
    logic        wvalid;
    logic [7:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bready;
    logic [63:0] ar_addr;
    logic        ar_valid;
    logic [3:0]  ar_id;
    logic [2:0]  ar_prot;
    logic        ar_ready;
    logic [63:0] rdata;
    logic        rvalid;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axi_lite_reg_slave dut (
        .aclk(aclk), .arst(arst),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_id(aw_id), .aw_prot(aw_prot), .aw_ready(aw_ready),
        .wdata(wdata), .wvalid(wvalid), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_id(ar_id), .ar_prot(ar_prot), .ar_ready(ar_ready),
        .rdata(rdata), .rvalid(rvalid), .rid(rid), .rresp(rresp), .rready(rready)
    );

    // Full write transaction; all driving happens at negedges.
    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input logic [3:0] id, output logic [1:0] resp, output logic [3:0] rsp_id);
        logic aw_done, w_done, hs_aw, hs_w;
        int cnt;
        aw_addr = addr; aw_id = id; wdata = data; wstrb = strb;
        aw_valid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; cnt = 0;
        while (!(aw_done && w_done) && cnt < 20) begin
            hs_aw = aw_valid && aw_ready;
            hs_w  = wvalid && wready;
            @(negedge aclk);
            cnt++;
            if (hs_aw) begin aw_done = 1'b1; aw_valid = 1'b0; end
            if (hs_w)  begin w_done  = 1'b1; wvalid   = 1'b0; end
        end
        aw_valid = 1'b0; wvalid = 1'b0;
        n_cmp++;
        if (!(aw_done && w_done) || bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_bvalid addr=%h: bvalid=%b handshakes=%b%b, required bvalid=1 one cycle after handshake",
                     addr, bvalid, aw_done, w_done);
        end
        resp = bresp; rsp_id = bid;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    // Full read transaction; checks rvalid arrives one cycle after the AR handshake.
    task automatic axi_read(input logic [63:0] addr, input logic [3:0] id,
                            output logic [63:0] data, output logic [1:0] resp, output logic [3:0] rsp_id);
        logic done, hs;
        int cnt;
        ar_addr = addr; ar_id = id; ar_valid = 1'b1;
        done = 1'b0; cnt = 0;
        while (!done && cnt < 20) begin
            hs = ar_valid && ar_ready;
            @(negedge aclk);
            cnt++;
            if (hs) begin done = 1'b1; ar_valid = 1'b0; end
        end
        ar_valid = 1'b0;
        n_cmp++;
        if (!done || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_rvalid addr=%h: rvalid=%b handshake=%b, required rvalid=1 one cycle after handshake",
                     addr, rvalid, done);
        end
        data = rdata; resp = rresp; rsp_id = rid;
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        arst = 1'b1;
        repeat (3) @(negedge aclk);
        n_cmp++;
        if ({aw_ready, wready, ar_ready, bvalid, rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: aw_ready/wready/ar_ready/bvalid/rvalid=%b, required 00000",
                     {aw_ready, wready, ar_ready, bvalid, rvalid});
        end
        arst = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if ({aw_ready, wready, ar_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_readies: aw_ready/wready/ar_ready=%b, required 111", {aw_ready, wready, ar_ready});
        end
        axi_read(64'h0, 4'h3, d, r, i);
        n_cmp++;
        if (d !== 64'h0 || r !== 2'b00 || i !== 4'h3) begin
            n_fail++;
            $display("FAIL reset_read0: rdata=%h rresp=%b rid=%h, required 0 00 3", d, r, i);
        end
        $display("test_reset: read 0x0 -> %h", d);
    endtask

    task automatic test_aw_w_together();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        axi_write(64'h18, 64'hDEADBEEF_CAFEF00D, 8'hFF, 4'h5, r, i);
        n_cmp++;
        if (r !== 2'b00 || i !== 4'h5) begin
            n_fail++;
            $display("FAIL together_bresp: bresp=%b bid=%h, required 00 5", r, i);
        end
        axi_read(64'h18, 4'h7, d, r, i);
        n_cmp++;
        if (d !== 64'hDEADBEEF_CAFEF00D || r !== 2'b00 || i !== 4'h7) begin
            n_fail++;
            $display("FAIL together_read: rdata=%h rresp=%b rid=%h, required deadbeefcafef00d 00 7", d, r, i);
        end
        $display("test_aw_w_together: reg3 -> %h", d);
    endtask

    task automatic test_w_before_aw();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        wdata = 64'h11111111_11111111; wstrb = 8'h0F; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        n_cmp++;
        if (wready !== 1'b0 || aw_ready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL have_w_readies: wready=%b aw_ready=%b bvalid=%b, required 0 1 0", wready, aw_ready, bvalid);
        end
        @(negedge aclk);
        aw_addr = 64'h18; aw_id = 4'h9; aw_valid = 1'b1;
        @(negedge aclk);
        aw_valid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b1 || bid !== 4'h9 || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL have_w_resp: bvalid=%b bid=%h bresp=%b, required 1 9 00", bvalid, bid, bresp);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        axi_read(64'h18, 4'h1, d, r, i);
        n_cmp++;
        if (d !== 64'hDEADBEEF_11111111) begin
            n_fail++;
            $display("FAIL have_w_data: rdata=%h, required deadbeef11111111", d);
        end
        $display("test_w_before_aw: reg3 -> %h", d);
    endtask

    task automatic test_backpressure();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        aw_addr = 64'h20; aw_id = 4'hA; wdata = 64'h01234567_89ABCDEF; wstrb = 8'hFF;
        aw_valid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        aw_valid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bvalid !== 1'b1 || bid !== 4'hA || bresp !== 2'b00 || aw_ready !== 1'b0 || wready !== 1'b0) begin
                n_fail++;
                $display("FAIL b_stall cycle %0d: bvalid=%b bid=%h bresp=%b aw_ready=%b wready=%b, required 1 a 00 0 0",
                         k, bvalid, bid, bresp, aw_ready, wready);
            end
            @(negedge aclk);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0 || aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_release: bvalid=%b aw_ready=%b, required 0 1", bvalid, aw_ready);
        end
        ar_addr = 64'h20; ar_id = 4'h6; ar_valid = 1'b1;
        @(negedge aclk);
        ar_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (rvalid !== 1'b1 || rdata !== 64'h01234567_89ABCDEF || rid !== 4'h6 || ar_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL r_stall cycle %0d: rvalid=%b rdata=%h rid=%h ar_ready=%b, required 1 0123456789abcdef 6 0",
                         k, rvalid, rdata, rid, ar_ready);
            end
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b0 || ar_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL r_release: rvalid=%b ar_ready=%b, required 0 1", rvalid, ar_ready);
        end
        $display("test_backpressure: B and R held 5 cycles");
    endtask

    task automatic test_miss();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        axi_write(64'h80, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 4'h2, r, i);
        n_cmp++;
        if (r !== MISS_EXP || i !== 4'h2) begin
            n_fail++;
            $display("FAIL miss_wr_0x80: bresp=%b bid=%h, required %b 2", r, i, MISS_EXP);
        end
        axi_read(64'h80, 4'h2, d, r, i);
        n_cmp++;
        if (d !== 64'h0 || r !== MISS_EXP) begin
            n_fail++;
            $display("FAIL miss_rd_0x80: rdata=%h rresp=%b, required 0 %b", d, r, MISS_EXP);
        end
        axi_write(64'h1_0000_0018, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 4'h4, r, i);
        n_cmp++;
        if (r !== MISS_EXP) begin
            n_fail++;
            $display("FAIL miss_wr_high: bresp=%b, required %b", r, MISS_EXP);
        end
        axi_read(64'h1_0000_0018, 4'h4, d, r, i);
        n_cmp++;
        if (d !== 64'h0 || r !== MISS_EXP) begin
            n_fail++;
            $display("FAIL miss_rd_high: rdata=%h rresp=%b, required 0 %b", d, r, MISS_EXP);
        end
        axi_read(64'h18, 4'h0, d, r, i);
        n_cmp++;
        if (d !== 64'hDEADBEEF_11111111 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_no_alias: reg3=%h rresp=%b, required deadbeef11111111 00", d, r);
        end
        axi_write(64'h7F, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 4'hF, r, i);
        axi_read(64'h78, 4'hE, d, r, i);
        n_cmp++;
        if (d !== 64'hA5A5A5A5_5A5A5A5A || r !== 2'b00 || i !== 4'hE) begin
            n_fail++;
            $display("FAIL last_reg: rdata=%h rresp=%b rid=%h, required a5a5a5a55a5a5a5a 00 e", d, r, i);
        end
        $display("test_miss: miss resp %b, reg15 -> %h", MISS_EXP, d);
    endtask

    task automatic test_wstrb_zero();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        axi_write(64'h18, 64'h0, 8'h00, 4'h8, r, i);
        n_cmp++;
        if (r !== 2'b00 || i !== 4'h8) begin
            n_fail++;
            $display("FAIL strb0_resp: bresp=%b bid=%h, required 00 8", r, i);
        end
        axi_read(64'h18, 4'h8, d, r, i);
        n_cmp++;
        if (d !== 64'hDEADBEEF_11111111) begin
            n_fail++;
            $display("FAIL strb0_data: rdata=%h, required deadbeef11111111", d);
        end
        $display("test_wstrb_zero: reg3 -> %h", d);
    endtask

    task automatic test_same_edge();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        axi_write(64'h8, 64'hAAAA0000_BBBB1111, 8'hFF, 4'h1, r, i);
        aw_addr = 64'h8; aw_id = 4'hC; wdata = 64'h12345678_9ABCDEF0; wstrb = 8'hFF;
        ar_addr = 64'h8; ar_id = 4'hD;
        aw_valid = 1'b1; wvalid = 1'b1; ar_valid = 1'b1;
        @(negedge aclk);
        aw_valid = 1'b0; wvalid = 1'b0; ar_valid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 64'hAAAA0000_BBBB1111 || rid !== 4'hD) begin
            n_fail++;
            $display("FAIL same_edge_old: bvalid=%b rvalid=%b rdata=%h rid=%h, required 1 1 aaaa0000bbbb1111 d",
                     bvalid, rvalid, rdata, rid);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        axi_read(64'h8, 4'h2, d, r, i);
        n_cmp++;
        if (d !== 64'h12345678_9ABCDEF0) begin
            n_fail++;
            $display("FAIL same_edge_new: rdata=%h, required 123456789abcdef0", d);
        end
        $display("test_same_edge: reg1 -> %h", d);
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; logic [1:0] r; logic [3:0] i;
        aw_addr = 64'h28; aw_id = 4'h3; wdata = 64'h55; wstrb = 8'hFF;
        aw_valid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        aw_valid = 1'b0; wvalid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: bvalid=%b, required 1", bvalid);
        end
        arst = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_bvalid: bvalid=%b, required 0", bvalid);
        end
        arst = 1'b0;
        @(negedge aclk);
        axi_read(64'h18, 4'h5, d, r, i);
        n_cmp++;
        if (d !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reg3: rdata=%h, required 0", d);
        end
        axi_read(64'h8, 4'h5, d, r, i);
        n_cmp++;
        if (d !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reg1: rdata=%h, required 0", d);
        end
        $display("test_reset_mid: registers back to reset value");
    endtask

    initial begin
        arst = 1'b1;
        aw_addr = '0; aw_valid = 1'b0; aw_id = '0; aw_prot = '0;
        wdata = '0; wvalid = 1'b0; wstrb = '0; bready = 1'b0;
        ar_addr = '0; ar_valid = 1'b0; ar_id = '0; ar_prot = '0; rready = 1'b0;
        @(negedge aclk);
        test_reset();
        test_aw_w_together();
        test_w_before_aw();
        test_backpressure();
        test_miss();
        test_wstrb_zero();
        test_same_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
